// File: rtl/icache_assoc_refill.sv
// rtl/icache_assoc_refill.sv - set-associative VLIW fetch cache with miss refill FSM; optional stats via ICACHE_STATS_EN
module icache_assoc_refill #(
  parameter int NFU                     = 2,
  parameter int NSETS                   = 64,
  parameter int NWAYS                   = 4,
  parameter int PHYSICAL_ADDRESS_LENGTH = 56
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               fetch_valid,
  output logic                               fetch_ready,
  input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] fetch_addr,
  output logic                               resp_valid,
  output logic [NFU*32-1:0]                  resp_data,
  output logic                               resp_error,
  input  logic                               flush,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [PHYSICAL_ADDRESS_LENGTH-1:0] mem_req_addr,
  input  logic                               mem_resp_valid,
  input  logic [NFU*32-1:0]                  mem_resp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                        stat_hits,
  output logic [31:0]                        stat_misses
`endif
);

  localparam int PAL   = PHYSICAL_ADDRESS_LENGTH;
  localparam int LINEW = NFU * 32;
  localparam int OFFW  = $clog2(NFU * 4);
  localparam int SETW  = $clog2(NSETS);
  localparam int WAYW  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int TAGW  = PAL - SETW - OFFW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_RESPOND
  } state_t;

  state_t            state;
  logic [PAL-1:0]    addr_q;
  logic [NWAYS-1:0]  valid_q  [NSETS];
  logic [WAYW-1:0]   victim_q [NSETS];
  logic [TAGW-1:0]   tag_mem  [NSETS][NWAYS];
  logic [LINEW-1:0]  data_mem [NSETS][NWAYS];

  logic [OFFW-1:0]   req_off;
  logic [SETW-1:0]   req_set;
  logic [TAGW-1:0]   req_tag;
  logic [WAYW-1:0]   victim_way;
  logic              hit;
  logic [LINEW-1:0]  hit_data;

  assign req_off    = addr_q[OFFW-1:0];
  assign req_set    = addr_q[OFFW+SETW-1:OFFW];
  assign req_tag    = addr_q[PAL-1:OFFW+SETW];
  assign victim_way = victim_q[req_set];

  // Only an idle, out-of-reset cache with no flush pending takes a new request
  assign fetch_ready = rst_n && (state == S_IDLE) && !flush;

  // Parallel tag compare across the ways of the captured set; lowest matching way wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!hit && valid_q[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
        hit      = 1'b1;
        hit_data = data_mem[req_set][w];
      end
    end
  end

  // Control FSM: accept, lookup, refill handshake, registered responses, valid/victim bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_error    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            for (int s = 0; s < NSETS; s++) begin
              valid_q[s]  <= '0;
              victim_q[s] <= '0;
            end
          end else if (fetch_valid) begin
            addr_q <= fetch_addr;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (req_off != '0) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_data  <= '0;
            state      <= S_IDLE;
          end else if (hit) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_data  <= hit_data;
            state      <= S_IDLE;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {req_tag, req_set, {OFFW{1'b0}}};
            state         <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[req_set][victim_way] <= 1'b1;
            victim_q[req_set] <= (victim_way == WAYW'(NWAYS - 1)) ? '0 : victim_way + 1'b1;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_data  <= mem_resp_data;
            state      <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits alone decide whether a way is usable
  always_ff @(posedge clk) begin
    if ((state == S_MISS_WAIT) && mem_resp_valid) begin
      tag_mem[req_set][victim_way]  <= req_tag;
      data_mem[req_set][victim_way] <= mem_resp_data;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters sampled at lookup; misaligned requests and flushes leave them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if ((state == S_LOOKUP) && (req_off == '0)) begin
      if (hit) begin
        if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_assoc_refill.sv
// tb/tb_icache_assoc_refill.sv - self-checking bench for icache_assoc_refill
module tb_icache_assoc_refill;
  localparam int PAL   = 56;
  localparam int LW    = 64;
  localparam int NSETS = 64;
  localparam int NWAYS = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fetch_valid = 1'b0;
  logic           flush = 1'b0;
  logic           mem_req_ready = 1'b0;
  logic           mem_resp_valid = 1'b0;
  logic [PAL-1:0] fetch_addr = '0;
  logic [LW-1:0]  mem_resp_data = '0;
  logic           fetch_ready, resp_valid, resp_error, mem_req_valid;
  logic [LW-1:0]  resp_data;
  logic [PAL-1:0] mem_req_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0]    stat_hits, stat_misses;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: per set, which line address each way holds, plus the round-robin pointer
  logic           m_ok   [NSETS][NWAYS];
  logic [PAL-1:0] m_line [NSETS][NWAYS];
  logic [LW-1:0]  m_data [NSETS][NWAYS];
  int             m_ptr  [NSETS];

  typedef struct {
    logic [PAL-1:0] addr;
    logic [LW-1:0]  md;
    int             rw;
    int             sw;
    int             kind;   // 0 hit, 1 miss, 2 misaligned
    logic [LW-1:0]  exp;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  icache_assoc_refill #(.NFU(2), .NSETS(NSETS), .NWAYS(NWAYS), .PHYSICAL_ADDRESS_LENGTH(PAL)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NSETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NWAYS; w++) m_ok[s][w] = 1'b0;
    end
  endtask

  // One full fetch transaction; also plays the memory side with the given request/response waits
  task automatic do_fetch(input logic [PAL-1:0] a, input logic [LW-1:0] md, input int rw, input int sw,
                          output logic rv, output logic [LW-1:0] rd, output logic re, output int lat,
                          output logic missed, output logic [PAL-1:0] maddr, output logic stable);
    int n, rq, rs;
    rv = 0; rd = '0; re = 0; lat = 0; missed = 0; maddr = '0; stable = 1; n = 0; rq = 0; rs = 0;
    @(negedge clk);
    while (!fetch_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    fetch_valid = 1'b1;
    fetch_addr  = a;
    @(posedge clk);
    #1 fetch_valid = 1'b0;
    while (!rv && lat < 100) begin
      @(negedge clk);
      if (resp_valid) begin
        rv = 1; rd = resp_data; re = resp_error;
      end else begin
        if (fetch_ready) stable = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (mem_req_valid) begin
          if (!missed) maddr = mem_req_addr;
          else if (mem_req_addr !== maddr) stable = 0;
          missed = 1;
          if (rq == rw) mem_req_ready = 1'b1;
          else rq++;
        end else if (missed) begin
          if (rs == sw) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = md;
          end else rs++;
        end
        lat++;
      end
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [PAL-1:0] a, input logic [LW-1:0] md,
                           input int rw, input int sw, input int kind, input logic [LW-1:0] exp);
    logic rv, re, missed, stable;
    logic [LW-1:0] rd;
    logic [PAL-1:0] maddr, la;
    int lat;
    la = a;
    la[2:0] = 3'b000;
    do_fetch(a, md, rw, sw, rv, rd, re, lat, missed, maddr, stable);
    chk({tag, "_resp_valid"}, 64'(rv), 64'd1);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_error"}, 64'(re), 64'(kind == 2));
    chk({tag, "_miss"}, 64'(missed), 64'(kind == 1));
    chk({tag, "_latency"}, 64'(lat), (kind == 1) ? 64'(3 + rw + sw) : 64'd1);
    chk({tag, "_stable"}, 64'(stable), 64'd1);
    if (kind == 1) chk({tag, "_mem_addr"}, 64'(maddr), 64'(la));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(resp_valid), 64'd0);
    chk({tag, "_hold"}, resp_data, rd);
  endtask

  task automatic random_fetch(input int i);
    logic [PAL-1:0] a, la;
    logic [LW-1:0] md, ed;
    int s, kind, pick;
    pick = $urandom_range(0, 2);
    s = (pick == 0) ? 0 : (pick == 1) ? 1 : 32;
    a = '0;
    a[9 +: 8] = 8'($urandom_range(0, 5));
    a[8:3] = 6'(s);
    if ($urandom_range(0, 9) == 0) a[2:0] = 3'($urandom_range(1, 7));
    la = a;
    la[2:0] = 3'b000;
    md = {$urandom, $urandom};
    if (a[2:0] != 3'b000) begin
      kind = 2; ed = '0;
    end else begin
      kind = 1; ed = md;
      for (int w = NWAYS - 1; w >= 0; w--)
        if (m_ok[s][w] && m_line[s][w] == la) begin
          kind = 0; ed = m_data[s][w];
        end
    end
    run_check($sformatf("rnd%0d", i), a, md, $urandom_range(0, 3), $urandom_range(0, 3), kind, ed);
    if (kind == 1) begin
      m_ok[s][m_ptr[s]]   = 1'b1;
      m_line[s][m_ptr[s]] = la;
      m_data[s][m_ptr[s]] = md;
      m_ptr[s] = (m_ptr[s] + 1) % NWAYS;
    end
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{56'h100, 64'hDEADBEEF_CAFEF00D, 0, 2, 1, 64'hDEADBEEF_CAFEF00D};
    tbl[1]  = '{56'h100, 64'h0,                 0, 0, 0, 64'hDEADBEEF_CAFEF00D};
    tbl[2]  = '{56'h104, 64'h0,                 0, 0, 2, 64'h0};
    tbl[3]  = '{56'h200, 64'h1111_1111_1111_1111, 0, 0, 1, 64'h1111_1111_1111_1111};
    tbl[4]  = '{56'h400, 64'h2222_2222_2222_2222, 5, 1, 1, 64'h2222_2222_2222_2222};
    tbl[5]  = '{56'h600, 64'h3333_3333_3333_3333, 1, 0, 1, 64'h3333_3333_3333_3333};
    tbl[6]  = '{56'h800, 64'h4444_4444_4444_4444, 0, 3, 1, 64'h4444_4444_4444_4444};
    tbl[7]  = '{56'hA00, 64'h5555_5555_5555_5555, 2, 2, 1, 64'h5555_5555_5555_5555};
    tbl[8]  = '{56'h400, 64'h0,                 0, 0, 0, 64'h2222_2222_2222_2222};
    tbl[9]  = '{56'h200, 64'h6666_6666_6666_6666, 0, 0, 1, 64'h6666_6666_6666_6666};
    tbl[10] = '{56'h400, 64'h7777_7777_7777_7777, 0, 0, 1, 64'h7777_7777_7777_7777};
    tbl[11] = '{56'h800, 64'h0,                 0, 0, 0, 64'h4444_4444_4444_4444};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_fetch_ready", 64'(fetch_ready), 64'd1);

    // directed table
    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].md, tbl[i].rw, tbl[i].sw, tbl[i].kind, tbl[i].exp);

    // flush wins over a same-cycle fetch
    @(negedge clk);
    flush = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr = 56'h100;
    #1 chk("flush_blocks_ready", 64'(fetch_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    fetch_valid = 1'b0;
    @(negedge clk);
    chk("flush_not_accepted", 64'(fetch_ready), 64'd1);
    chk("flush_no_resp", 64'(resp_valid), 64'd0);
    run_check("flush_refetch", 56'h100, 64'h0123_4567_89AB_CDEF, 0, 0, 1, 64'h0123_4567_89AB_CDEF);
    run_check("flush_other", 56'h800, 64'h8888_8888_8888_8888, 1, 1, 1, 64'h8888_8888_8888_8888);

    // reset while waiting for refill data, then a stale response
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr = 56'h300;
    @(posedge clk);
    #1 fetch_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_req_seen", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    chk("mrst_in_wait", 64'(mem_req_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready_low", 64'(fetch_ready), 64'd0);
    chk("mrst_req_low", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      if (resp_valid) n++;
      @(negedge clk);
    end
    chk("mrst_stale_ignored", 64'(n), 64'd0);
    chk("mrst_idle", 64'(fetch_ready), 64'd1);
    run_check("mrst_refetch", 56'h300, 64'h9999_0000_9999_0000, 0, 0, 1, 64'h9999_0000_9999_0000);

    // randomized traffic against the model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        model_clear();
      end
      random_fetch(i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
